// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one single-port RAM between the instruction cache and the data
//   cache of a core. Accesses are word-granular and one at a time. The dcache
//   has fixed priority. A starvation counter lets the icache win the next
//   grant after STARVE_LIMIT back-to-back dcache completions that happened
//   while a fetch was waiting.
//
// Ports:
//   CLK, RST           clock (rising edge) and synchronous active-high reset
//   iREN, iaddr        icache fetch request and word address
//   iwait, iload       icache handshake: iwait is low only in the cycle that
//                      iload carries the fetched word
//   dREN, dWEN         dcache read / write request (never both high)
//   daddr, dstore      dcache word address and write data
//   dwait, dload       dcache handshake: dwait is low only in the completion
//                      cycle, and dload carries the read data in that cycle
//   ramREN, ramWEN     RAM read / write strobes
//   ramaddr, ramstore  RAM address and write data
//   ramload            RAM read data
//   ramstate           00 FREE, 01 BUSY, 10 ACCESS (done), 11 ERROR
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int WORD_W       = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IGRANT = 2'b01,
        DGRANT = 2'b10
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic [3:0] err_cnt_q;
    logic [3:0] err_cnt_d;

    logic       d_req;

    assign d_req = dREN | dWEN;

    // State and counter registers; reset returns to IDLE with both
    // counters cleared.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            err_cnt_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Next-state, counter and output logic. All outputs are combinational so
    // the granted requester sees ramload and its wait pulse in the same cycle
    // the RAM reports ACCESS, and a dropped request pulls the strobes down
    // immediately. While RST is high every output stays at its idle value, so
    // a completion in the reset cycle is suppressed.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        err_cnt_d    = err_cnt_q;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = '0;
        dload        = '0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;

        if (!RST) begin
            unique case (state_q)
                IDLE: begin
                    err_cnt_d = 4'd0;
                    // The dcache wins unless the waiting fetch has already
                    // been passed over STARVE_LIMIT times in a row.
                    if (d_req && !(iREN && (starve_cnt_q == STARVE_MAX))) begin
                        state_d = DGRANT;
                    end else if (iREN) begin
                        state_d = IGRANT;
                    end
                end

                IGRANT: begin
                    if (!iREN) begin
                        // Aborted fetch: no strobe, no pulse, counter kept.
                        state_d = IDLE;
                    end else begin
                        ramREN  = 1'b1;
                        ramaddr = iaddr;
                        if (ramstate == RAM_ACCESS) begin
                            iwait        = 1'b0;
                            iload        = ramload;
                            starve_cnt_d = 4'd0;
                            err_cnt_d    = 4'd0;
                            state_d      = IDLE;
                        end else if (ramstate == RAM_ERROR) begin
                            if (err_cnt_q != 4'hF) begin
                                err_cnt_d = err_cnt_q + 4'd1;
                            end
                        end
                    end
                end

                DGRANT: begin
                    if (!d_req) begin
                        state_d = IDLE;
                    end else begin
                        ramREN   = dREN;
                        ramWEN   = dWEN;
                        ramaddr  = daddr;
                        ramstore = dstore;
                        if (ramstate == RAM_ACCESS) begin
                            dwait     = 1'b0;
                            dload     = ramload;
                            err_cnt_d = 4'd0;
                            state_d   = IDLE;
                            // Only completions that overtook a waiting fetch
                            // count towards starvation.
                            if (iREN) begin
                                if (starve_cnt_q >= STARVE_MAX) begin
                                    starve_cnt_d = STARVE_MAX;
                                end else begin
                                    starve_cnt_d = starve_cnt_q + 4'd1;
                                end
                            end else begin
                                starve_cnt_d = 4'd0;
                            end
                        end else if (ramstate == RAM_ERROR) begin
                            if (err_cnt_q != 4'hF) begin
                                err_cnt_d = err_cnt_q + 4'd1;
                            end
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // The RAM never sees a read and a write strobe together.
    a_strobe_exclusive: assert property (@(posedge CLK) !(ramREN && ramWEN));

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter: a table of directed vectors, a few
// hand-written multi-cycle sequences, then randomized traffic against a
// word-memory reference model with a starvation bound.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int          LIMIT      = 4;
    localparam logic [1:0]  RS_FREE    = 2'b00;
    localparam logic [1:0]  RS_BUSY    = 2'b01;
    localparam logic [1:0]  RS_ACCESS  = 2'b10;
    localparam logic [1:0]  RS_ERROR   = 2'b11;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = 2'b00;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(32), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        iren;
        logic [31:0] ia;
        logic        dren;
        logic        dwen;
        logic [31:0] da;
        logic [31:0] ds;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] ref_mem [16];
    logic [31:0] ram_mem [16];

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, then wait for
    // the falling edge where outputs are sampled.
    task automatic apply_stimulus(input logic rst, input logic iren,
                                  input logic [31:0] ia, input logic dren,
                                  input logic dwen, input logic [31:0] da,
                                  input logic [31:0] ds, input logic [1:0] rs,
                                  input logic [31:0] rl);
        @(posedge CLK);
        #1;
        RST      = rst;
        iREN     = iren;
        iaddr    = ia;
        dREN     = dren;
        dWEN     = dwen;
        daddr    = da;
        dstore   = ds;
        ramstate = rs;
        ramload  = rl;
        @(negedge CLK);
    endtask

    function automatic vec_t mk(input logic rst, input logic iren,
                                input logic [31:0] ia, input logic dren,
                                input logic dwen, input logic [31:0] da,
                                input logic [31:0] ds, input logic [1:0] rs,
                                input logic [31:0] rl, input logic eiw,
                                input logic edw, input logic eren,
                                input logic ewen, input logic [31:0] eaddr,
                                input logic [31:0] estore,
                                input logic [31:0] eil,
                                input logic [31:0] edl);
        vec_t v;
        v.rst = rst; v.iren = iren; v.ia = ia; v.dren = dren; v.dwen = dwen;
        v.da = da; v.ds = ds; v.rs = rs; v.rl = rl;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_ren = eren; v.e_wen = ewen;
        v.e_addr = eaddr; v.e_store = estore; v.e_iload = eil;
        v.e_dload = edl;
        return v;
    endfunction

    task automatic do_reset();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, RS_FREE, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, RS_FREE, 0);
    endtask

    initial begin
        // ---------------- directed vector table ----------------
        // reset, then lone fetch with two BUSY cycles
        vecs.push_back(mk(1,0,32'h0,0,0,32'h0,32'h0,RS_FREE,32'h0,
                          1,1,0,0,32'h0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h40,0,0,32'h0,32'h0,RS_FREE,32'h0,
                          1,1,0,0,32'h0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h40,0,0,32'h0,32'h0,RS_BUSY,32'h0,
                          1,1,1,0,32'h40,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h40,0,0,32'h0,32'h0,RS_BUSY,32'h0,
                          1,1,1,0,32'h40,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h40,0,0,32'h0,32'h0,RS_ACCESS,32'h24010005,
                          0,1,1,0,32'h40,32'h0,32'h24010005,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,32'h0,RS_FREE,32'h0,
                          1,1,0,0,32'h0,32'h0,32'h0,32'h0));
        // collision: dcache write first, one IDLE cycle, then the fetch
        vecs.push_back(mk(0,1,32'h80,0,1,32'h100,32'hDEADBEEF,RS_FREE,32'h0,
                          1,1,0,0,32'h0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h80,0,1,32'h100,32'hDEADBEEF,RS_ACCESS,
                          32'h11111111,
                          1,0,0,1,32'h100,32'hDEADBEEF,32'h0,32'h11111111));
        vecs.push_back(mk(0,1,32'h80,0,0,32'h0,32'h0,RS_ACCESS,32'h22222222,
                          1,1,0,0,32'h0,32'h0,32'h0,32'h0));
        vecs.push_back(mk(0,1,32'h80,0,0,32'h0,32'h0,RS_ACCESS,32'hCAFEF00D,
                          0,1,1,0,32'h80,32'h0,32'hCAFEF00D,32'h0));
        vecs.push_back(mk(0,0,32'h0,0,0,32'h0,32'h0,RS_FREE,32'h0,
                          1,1,0,0,32'h0,32'h0,32'h0,32'h0));

        foreach (vecs[k]) begin
            apply_stimulus(vecs[k].rst, vecs[k].iren, vecs[k].ia,
                           vecs[k].dren, vecs[k].dwen, vecs[k].da,
                           vecs[k].ds, vecs[k].rs, vecs[k].rl);
            check_output($sformatf("vec%0d_iwait", k), 32'(iwait),
                         32'(vecs[k].e_iwait));
            check_output($sformatf("vec%0d_dwait", k), 32'(dwait),
                         32'(vecs[k].e_dwait));
            check_output($sformatf("vec%0d_ramREN", k), 32'(ramREN),
                         32'(vecs[k].e_ren));
            check_output($sformatf("vec%0d_ramWEN", k), 32'(ramWEN),
                         32'(vecs[k].e_wen));
            check_output($sformatf("vec%0d_ramaddr", k), ramaddr,
                         vecs[k].e_addr);
            check_output($sformatf("vec%0d_ramstore", k), ramstore,
                         vecs[k].e_store);
            check_output($sformatf("vec%0d_iload", k), iload,
                         vecs[k].e_iload);
            check_output($sformatf("vec%0d_dload", k), dload,
                         vecs[k].e_dload);
        end

        // ---------------- starvation guard ----------------
        begin
            int  dcount;
            bit  got_i;
            dcount = 0;
            got_i  = 0;
            do_reset();
            for (int c = 0; c < 60 && !got_i; c++) begin
                apply_stimulus(0, 1, 32'h44, 1, 0, 32'h200, 32'h0,
                               RS_ACCESS, 32'h5A5A0000 + 32'(c));
                if (!dwait) dcount++;
                if (!iwait) got_i = 1;
            end
            check_output("starve_i_granted", 32'(got_i), 32'd1);
            check_output("starve_d_before_i", 32'(dcount), 32'(LIMIT));
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, RS_FREE, 0);
            check_output("starve_cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
        end

        // ---------------- abort during BUSY ----------------
        do_reset();
        apply_stimulus(0, 0, 0, 1, 0, 32'h200, 0, RS_BUSY, 0);
        apply_stimulus(0, 0, 0, 1, 0, 32'h200, 0, RS_BUSY, 0);
        check_output("abort_granted_ren", 32'(ramREN), 32'd1);
        check_output("abort_granted_addr", ramaddr, 32'h200);
        apply_stimulus(0, 0, 0, 0, 0, 32'h200, 0, RS_BUSY, 0);
        check_output("abort_ren_drop", 32'(ramREN), 32'd0);
        check_output("abort_no_dwait", 32'(dwait), 32'd1);
        apply_stimulus(0, 0, 0, 1, 0, 32'h200, 0, RS_ACCESS, 32'h77);
        check_output("abort_back_idle_dwait", 32'(dwait), 32'd1);
        check_output("abort_back_idle_ren", 32'(ramREN), 32'd0);
        apply_stimulus(0, 0, 0, 1, 0, 32'h200, 0, RS_ACCESS, 32'h77);
        check_output("abort_regrant_dwait", 32'(dwait), 32'd0);
        check_output("abort_regrant_dload", dload, 32'h77);

        // ---------------- ERROR retry ----------------
        do_reset();
        apply_stimulus(0, 0, 0, 1, 0, 32'h300, 0, RS_FREE, 0);
        for (int e = 0; e < 3; e++) begin
            apply_stimulus(0, 0, 0, 1, 0, 32'h300, 0, RS_ERROR, 32'hBADBAD00);
            check_output($sformatf("err%0d_ren", e), 32'(ramREN), 32'd1);
            check_output($sformatf("err%0d_dwait", e), 32'(dwait), 32'd1);
            check_output($sformatf("err%0d_addr", e), ramaddr, 32'h300);
        end
        apply_stimulus(0, 0, 0, 1, 0, 32'h300, 0, RS_ACCESS, 32'h12345678);
        check_output("err_cnt_reached", 32'(dut.err_cnt_q), 32'd3);
        check_output("err_done_dwait", 32'(dwait), 32'd0);
        check_output("err_done_dload", dload, 32'h12345678);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, RS_FREE, 0);
        check_output("err_cnt_cleared", 32'(dut.err_cnt_q), 32'd0);
        check_output("err_single_pulse", 32'(dwait), 32'd1);

        // ---------------- reset mid-access ----------------
        do_reset();
        apply_stimulus(0, 1, 32'h60, 0, 0, 0, 0, RS_FREE, 0);
        apply_stimulus(0, 1, 32'h60, 0, 0, 0, 0, RS_BUSY, 0);
        check_output("rst_mid_granted", 32'(ramREN), 32'd1);
        apply_stimulus(1, 1, 32'h60, 0, 0, 0, 0, RS_ACCESS, 32'hAAAA5555);
        check_output("rst_cycle_iwait", 32'(iwait), 32'd1);
        check_output("rst_cycle_iload", iload, 32'h0);
        apply_stimulus(0, 1, 32'h60, 0, 0, 0, 0, RS_ACCESS, 32'hAAAA5555);
        check_output("rst_after_ren", 32'(ramREN), 32'd0);
        check_output("rst_after_iwait", 32'(iwait), 32'd1);
        check_output("rst_after_starve", 32'(dut.starve_cnt_q), 32'd0);
        apply_stimulus(0, 1, 32'h60, 0, 0, 0, 0, RS_ACCESS, 32'hAAAA5555);
        check_output("rst_reissue_iwait", 32'(iwait), 32'd0);
        check_output("rst_reissue_iload", iload, 32'hAAAA5555);
        check_output("rst_reissue_addr", ramaddr, 32'h60);

        // ---------------- randomized traffic ----------------
        begin
            bit i_act, d_act, d_wr;
            int i_age, d_age, d_while_i;
            int r;
            i_act = 0; d_act = 0; d_wr = 0;
            i_age = 0; d_age = 0; d_while_i = 0;
            for (int k = 0; k < 16; k++) begin
                ref_mem[k] = $urandom;
                ram_mem[k] = ref_mem[k];
            end
            do_reset();
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(posedge CLK);
                #1;
                if (!i_act && $urandom_range(0, 3) == 0) begin
                    i_act     = 1;
                    iaddr     = $urandom;
                    i_age     = 0;
                    d_while_i = 0;
                end
                if (!d_act && $urandom_range(0, 2) == 0) begin
                    d_act  = 1;
                    d_wr   = 1'($urandom_range(0, 1));
                    daddr  = $urandom;
                    dstore = $urandom;
                    d_age  = 0;
                end else if (d_act && $urandom_range(0, 19) == 0) begin
                    d_act = 0;
                end
                iREN = i_act;
                dREN = d_act && !d_wr;
                dWEN = d_act && d_wr;
                r = $urandom_range(0, 9);
                ramstate = (r < 2) ? RS_FREE : (r < 5) ? RS_BUSY :
                           (r < 6) ? RS_ERROR : RS_ACCESS;
                #1;
                ramload = (ramstate == RS_ACCESS) ? ram_mem[ramaddr[3:0]]
                                                  : $urandom;
                @(negedge CLK);

                check_output("rnd_dual_strobe", 32'(ramREN && ramWEN), 32'd0);
                check_output("rnd_dual_pulse", 32'(!iwait && !dwait), 32'd0);
                if (!iREN) check_output("rnd_iwait_idle", 32'(iwait), 32'd1);
                if (!(dREN || dWEN))
                    check_output("rnd_dwait_idle", 32'(dwait), 32'd1);

                if (ramWEN && ramstate == RS_ACCESS)
                    ram_mem[ramaddr[3:0]] = ramstore;

                if (iREN && !iwait) begin
                    check_output("rnd_iload", iload, ref_mem[iaddr[3:0]]);
                    check_output("rnd_i_on_access", 32'(ramstate), 32'(RS_ACCESS));
                    i_act     = 0;
                    d_while_i = 0;
                end
                if ((dREN || dWEN) && !dwait) begin
                    check_output("rnd_d_addr", ramaddr, daddr);
                    if (d_wr) ref_mem[daddr[3:0]] = dstore;
                    else check_output("rnd_dload", dload, ref_mem[daddr[3:0]]);
                    if (iREN) begin
                        d_while_i++;
                        check_output("rnd_starve_bound",
                                     32'(d_while_i <= LIMIT), 32'd1);
                    end
                    d_act = 0;
                end

                if (i_act) i_age++;
                if (d_act) d_age++;
                if (i_age > 200) begin
                    check_output("rnd_i_timeout", 32'(i_age), 32'd200);
                    i_act = 0;
                    i_age = 0;
                end
                if (d_age > 200) begin
                    check_output("rnd_d_timeout", 32'(d_age), 32'd200);
                    d_act = 0;
                    d_age = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always ends on its own.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation ran past its time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter between the instruction cache and the data cache of one core.
- Serialises word-granular icache fetches and dcache reads/writes onto one RAM port. Returns per-requester wait/load handshakes.
- Fixed dcache priority with a starvation guard so fetch always progresses.
- Sits between the two caches and the RAM model/bus.

Parameters:
STARVE_LIMIT, 4, consecutive dcache grants allowed while iREN is pending before the icache wins the next grant (1..15)
ADDR_W, 32, address width
WORD_W, 32, data word width

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
iREN  in  1  icache read request, held until iwait low
iaddr  in  ADDR_W  icache word address
iwait  out  1  low for exactly the cycle iload is valid
iload  out  WORD_W  fetched instruction word
dREN  in  1  dcache read request
dWEN  in  1  dcache write request (dREN and dWEN never both high)
daddr  in  ADDR_W  dcache word address
dstore  in  WORD_W  dcache write data
dwait  out  1  low for exactly the completion cycle of a dcache access
dload  out  WORD_W  dcache read data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS (done this cycle), 11 ERROR

Behaviour:
- Clock CLK; reset RST is synchronous and active-high.
- States: IDLE, IGRANT, DGRANT. Reset: state=IDLE, starve_cnt=0.
- Reset outputs: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- IDLE: no RAM strobe; iwait=dwait=1.
  - Next state DGRANT if (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT).
  - Else IGRANT if iREN.
  - Else IDLE.
- IGRANT: ramREN=1, ramaddr=iaddr (combinational pass-through, follows live iaddr).
  - ramstate==ACCESS: iwait=0, iload=ramload this cycle; starve_cnt<=0; next IDLE.
- DGRANT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - ramstate==ACCESS: dwait=0, dload=ramload (don't-care on writes, driven anyway); next IDLE.
  - On that same completion cycle: starve_cnt<=starve_cnt+1 if iREN else 0, saturating at STARVE_LIMIT.
- Outside the completion cycle: iwait=dwait=1, iload=dload=0. The non-granted requester always sees wait=1.
- Minimum latency: request first seen in IDLE at cycle n; RAM strobe from n+1; earliest completion n+1 (RAM returns ACCESS same cycle). Back-to-back accesses cost one IDLE cycle between grants.
- BUSY/FREE in a grant state: hold state and strobes, wait=1.
- ERROR in a grant state:
  - Treated as BUSY: strobes held, access retried, wait stays 1.
  - err_cnt (4-bit, saturating) increments per ERROR cycle; cleared on ACCESS and in IDLE. Internal only, exposed for assertions.
- Abort: granted requester drops its request before ACCESS → next cycle IDLE, strobes drop that cycle (combinational from request), no wait pulse, starve_cnt unchanged.
- Simultaneous iREN and dREN/dWEN in IDLE: dcache wins unless starve_cnt==STARVE_LIMIT, in which case icache wins. After the icache completion, starve_cnt=0.
- A grant is never pre-empted mid-access by the other requester.
- Grant-state strobes: exactly one of ramREN/ramWEN high, unless the requester has dropped its request (abort cycle).
- RST in any state, including mid-access with ramstate BUSY: next cycle IDLE, all outputs at reset values, counters 0. No completion pulse is emitted in the reset cycle.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x0000_0040; RAM BUSY 2 cycles then ACCESS with ramload=0x2401_0005 → ramREN high 3 cycles, ramaddr=0x40, iwait low exactly 1 cycle with iload=0x2401_0005, then IDLE.
- Collision: iREN and dWEN (daddr=0x100, dstore=0xDEAD_BEEF) rise together → DGRANT first with ramWEN=1, ramstore=0xDEADBEEF; after dwait pulse, one IDLE cycle, then IGRANT.
- Starvation: iREN held, dREN re-asserted continuously, STARVE_LIMIT=4 → 4 dcache completions, then icache granted, starve_cnt returns to 0.
- Abort: dREN to 0x200, dREN drops during BUSY → ramREN low that cycle, IDLE next, dwait never pulses.
- Error retry: ramstate ERROR 3 cycles then ACCESS, ramload=0x1234_5678 → strobes held throughout, err_cnt reaches 3, single dwait pulse with dload=0x1234_5678, err_cnt then 0.
- Reset mid-access: RST=1 for 1 cycle during IGRANT with BUSY → next cycle IDLE, ramREN=0, iwait=1, no iload pulse; re-issued iREN completes normally.
